mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 68 ++++++
 tb/tb_mem_stage.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: word-addressed data memory, M->W pipeline register and write-back mux.
// Optional macro DM_MISALIGN_TRAP_EN makes misaligned loads/stores raise DMErr.
module mem_stage #(
   parameter int sizeVal = 32,
   parameter int sizeAd  = 5,
   parameter int DMDepth = 256
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               RFWEM,
   input  logic               MtoRFSelM,
   input  logic               DMWEM,
   input  logic [sizeAd-1:0]  RFAM,
   input  logic [sizeVal-1:0] ALUOutM,
   input  logic [sizeVal-1:0] DMdinM,
   output logic               RFWEW,
   output logic               MtoRFSelW,
   output logic [sizeAd-1:0]  RFAW,
   output logic [sizeVal-1:0] ALUOutW,
   output logic [sizeVal-1:0] DMOutW,
   output logic [sizeVal-1:0] ResultW,
   output logic               DMErr
);
   localparam int AW = $clog2(DMDepth);

   logic [sizeVal-1:0] dm [DMDepth];
   logic [AW-1:0]      idx;
   logic               access;
   logic               oor;
   logic               bad;

   assign idx    = ALUOutM[AW+1:2];
   assign access = DMWEM | MtoRFSelM;
   // Any address bit at or above the memory's byte span means out of range.
   assign oor    = |(ALUOutM >> (AW + 2));

`ifdef DM_MISALIGN_TRAP_EN
   assign bad = access & (oor | (|ALUOutM[1:0]));
`else
   assign bad = access & oor;
`endif

   always_ff @(posedge clk) begin
      if (!rst && DMWEM && !bad)
         dm[idx] <= DMdinM;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         RFWEW     <= 1'b0;
         MtoRFSelW <= 1'b0;
         RFAW      <= '0;
         ALUOutW   <= '0;
         DMOutW    <= '0;
         DMErr     <= 1'b0;
      end else begin
         RFWEW     <= RFWEM;
         MtoRFSelW <= MtoRFSelM;
         RFAW      <= RFAM;
         ALUOutW   <= ALUOutM;
         DMOutW    <= bad ? '0 : dm[idx];
         if (bad)
            DMErr <= 1'b1;
      end
   end

   assign ResultW = MtoRFSelW ? DMOutW : ALUOutW;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver pushes reference-model results, monitor pops and compares.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        RFWEM = 1'b0, MtoRFSelM = 1'b0, DMWEM = 1'b0;
   logic [4:0]  RFAM = '0;
   logic [31:0] ALUOutM = '0, DMdinM = '0;
   logic        RFWEW, MtoRFSelW, DMErr;
   logic [4:0]  RFAW;
   logic [31:0] ALUOutW, DMOutW, ResultW;

   mem_stage dut (
      .clk(clk), .rst(rst), .RFWEM(RFWEM), .MtoRFSelM(MtoRFSelM), .DMWEM(DMWEM),
      .RFAM(RFAM), .ALUOutM(ALUOutM), .DMdinM(DMdinM), .RFWEW(RFWEW),
      .MtoRFSelW(MtoRFSelW), .RFAW(RFAW), .ALUOutW(ALUOutW), .DMOutW(DMOutW),
      .ResultW(ResultW), .DMErr(DMErr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rfwe;
      logic        msel;
      logic [4:0]  rfa;
      logic [31:0] alu;
      logic [31:0] dmout;
      logic [31:0] result;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] ref_mem [256];
   logic        ref_err = 1'b0;
   int          checks = 0;
   int          errors = 0;
   bit          done = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: byte addresses, word = addr/4, memory holds 256 words (1024 bytes).
   task automatic issue(input logic r, input logic rfwe, input logic msel, input logic dmwe,
                        input logic [4:0] rfa, input logic [31:0] alu, input logic [31:0] din);
      exp_t e;
      bit   is_access, is_bad;
      int   word;
      @(negedge clk);
      rst = r; RFWEM = rfwe; MtoRFSelM = msel; DMWEM = dmwe;
      RFAM = rfa; ALUOutM = alu; DMdinM = din;
      word      = int'((alu / 4) % 256);
      is_access = dmwe || msel;
      is_bad    = is_access && (alu >= 32'd1024);
`ifdef DM_MISALIGN_TRAP_EN
      if (is_access && (alu % 4 != 0)) is_bad = 1;
`endif
      if (r) begin
         e = '{rfwe: 0, msel: 0, rfa: 0, alu: 0, dmout: 0, result: 0, err: 0};
         ref_err = 0;
      end else begin
         e.rfwe  = rfwe;
         e.msel  = msel;
         e.rfa   = rfa;
         e.alu   = alu;
         e.dmout = is_bad ? 32'd0 : ref_mem[word];
         if (dmwe && !is_bad) ref_mem[word] = din;
         if (is_bad) ref_err = 1;
         e.err    = ref_err;
         e.result = msel ? e.dmout : alu;
      end
      sb.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("RFWEW", 32'(RFWEW), 32'(e.rfwe));
            chk("MtoRFSelW", 32'(MtoRFSelW), 32'(e.msel));
            chk("RFAW", 32'(RFAW), 32'(e.rfa));
            chk("ALUOutW", ALUOutW, e.alu);
            chk("DMOutW", DMOutW, e.dmout);
            chk("ResultW", ResultW, e.result);
            chk("DMErr", 32'(DMErr), 32'(e.err));
         end
      end
   end

   initial begin : driver
      int sel;
      logic [31:0] a;
      issue(1, 1, 1, 1, 5'd7, 32'h10, 32'hFFFF_FFFF);
      issue(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 256; i++)
         issue(0, 0, 0, 1, 0, 32'(i * 4), $urandom);
      issue(1, 0, 0, 0, 0, 0, 0);
      // store then dependent load, ALU op
      issue(0, 0, 0, 1, 0, 32'h10, 32'hDEAD_BEEF);
      issue(0, 1, 1, 0, 5'd8, 32'h10, 0);
      issue(0, 1, 0, 0, 5'd3, 32'h1234, 0);
      issue(0, 1, 0, 0, 5'd4, 32'hFFFF_0000, 0);
      // misaligned store, then read back word 4
      issue(0, 0, 0, 1, 0, 32'h12, 32'h55);
      issue(0, 1, 1, 0, 5'd1, 32'h10, 0);
      issue(1, 0, 0, 0, 0, 0, 0);
      // out of range store/load and boundary word
      issue(0, 0, 0, 1, 0, 32'h400, 32'hCAFE_0001);
      issue(0, 1, 1, 0, 5'd2, 32'h0, 0);
      issue(0, 1, 1, 0, 5'd2, 32'h400, 0);
      issue(0, 0, 0, 1, 0, 32'h3FC, 32'h1357_9BDF);
      issue(0, 1, 1, 0, 5'd9, 32'h3FC, 0);
      issue(0, 1, 1, 1, 5'd9, 32'h3FC, 32'h2468_ACE0);
      issue(0, 1, 1, 0, 5'd9, 32'h3FC, 0);
      // store blocked by reset
      issue(1, 1, 0, 1, 5'd5, 32'h20, 32'hBAD0_BAD0);
      issue(0, 1, 1, 0, 5'd6, 32'h20, 0);
      // back-to-back stores and loads
      issue(0, 0, 0, 1, 0, 32'h0, 32'h1111_1111);
      issue(0, 0, 0, 1, 0, 32'h4, 32'h2222_2222);
      issue(0, 1, 1, 0, 5'd10, 32'h0, 0);
      issue(0, 1, 1, 0, 5'd11, 32'h4, 0);
      for (int i = 0; i < 3000; i++) begin
         sel = int'($urandom_range(0, 99));
         if (sel < 80)      a = 32'($urandom_range(0, 255) * 4);
         else if (sel < 90) a = 32'($urandom_range(0, 1023));
         else               a = $urandom;
         issue(($urandom_range(0, 99) < 2), 1'($urandom), 1'($urandom), 1'($urandom),
               5'($urandom), a, $urandom);
      end
      issue(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end
endmodule
